ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register of the pipelined MIPS core.
//  Consumes the 4-bit ALU_control code from the ALU controller and the ID/EX operands.
//  Computes the ALU result and zero flag, then registers them with the MEM-stage control bits.
//  Supports pipeline stall (hold) and flush (bubble).
// PARAMETERS
//  DW   16  datapath width (operands, result, store data)
//  RW   3   destination register address width
// PORTS
//  clk             in   1    rising-edge clock
//  rst             in   1    synchronous reset, active high
//  ex_valid        in   1    EX slot holds a real instruction
//  alu_control     in   4    op code from ALU controller
//  alu_a           in   DW   operand A (post-forwarding)
//  alu_b           in   DW   operand B / immediate / shift amount
//  rd_addr         in   RW   destination register
//  reg_write_in    in   1    instr writes register file
//  mem_read_in     in   1    instr is a load
//  mem_write_in    in   1    instr is a store
//  store_data_in   in   DW   data for store
//  stall           in   1    hold EX/MEM contents
//  flush           in   1    replace EX/MEM contents with bubble
//  mem_valid       out  1    EX/MEM holds real instruction
//  mem_alu_result  out  DW   registered ALU result
//  mem_zero        out  1    registered (result == 0)
//  mem_rd_addr     out  RW   registered destination
//  mem_reg_write   out  1    registered reg_write
//  mem_mem_read    out  1    registered mem_read
//  mem_mem_write   out  1    registered mem_write
//  mem_store_data  out  DW   registered store data
//  mem_ovf         out  1    signed overflow flag (see CONFIGURATION)
//  err_illegal     out  1    sticky: illegal alu_control accepted
// BEHAVIOUR
//  - Single clock domain, clk, reset on rst (synchronous, active high); fully synchronous; 1-cycle latency, EX inputs -> EX/MEM outputs.
//  - Reset: all outputs 0, including err_illegal.
//  - Per-edge priority: rst > flush > stall > load.
//  - flush: bubble loaded; mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_ovf = 0; data fields = 0.
//  - flush and stall asserted together: flush wins.
//  - stall (no flush): every register, err_illegal included, holds its value.
//  - load with ex_valid=0: same as bubble.
//  - load with ex_valid=1: register the result and pass the control bits through.
//  - Op codes:
//      0000 ADD a+b, 0001 SUB a-b, 0010 AND, 0011 OR, 0100 NOR, 0101 XOR.
//      0110 SLL a<<s, 0111 SRL a>>s (logical).
//      s = alu_b[$clog2(DW)-1:0]; upper bits of alu_b ignored.
//      1000 pass alu_a.
//  - ADD/SUB wrap modulo 2^DW; carry discarded.
//  - mem_zero = (result == 0); used by beq/bne.
//  - Illegal codes are 1001-1111 or any X/Z bit. On load with ex_valid=1:
//      result = 0; mem_valid = 1; reg_write, mem_read, mem_write = 0.
//      err_illegal set; it stays set until rst.
//  - Reset mid-stall or mid-flush: reset dominates; the next cycle starts from the reset state.
// CONFIGURATION
//  ALU_OVF_EN defined:
//    - mem_ovf = signed overflow of ADD/SUB on loaded instr.
//    - Overflow forces mem_reg_write = 0 (trap-style suppression).
//    - mem_valid stays 1.
//  ALU_OVF_EN undefined: mem_ovf tied 0; no suppression; ADD/SUB simply wrap.
// TESTING
//  1. ADD a=0x7FFF b=0x0001 reg_write=1 -> next cycle result 0x8000, zero=0.
//     With ALU_OVF_EN: mem_ovf=1, mem_reg_write=0. Without: mem_ovf=0, mem_reg_write=1.
//  2. SUB a=0x1234 b=0x1234 -> result 0x0000, mem_zero=1. NOR 0x0F0F,0x00FF -> 0xF000.
//  3. SLL a=0x0001 b=0x0013 -> 0x0008 (s=3). SRL a=0x8000 b=0x000F -> 0x0001.
//  4. Load ADD result 0x0005, then stall 3 cycles while inputs change.
//     -> outputs hold 0x0005. On release, new result appears one cycle later.
//  5. stall=1 and flush=1 same cycle with a valid load word -> mem_valid=0, all control bits 0.
//  6. alu_control=1010, ex_valid=1, mem_write=1 -> result 0, mem_mem_write=0, err_illegal=1.
//     err_illegal stays 1 through later legal ops until rst pulse, then 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: MIPS execute stage ALU plus EX/MEM pipeline register with stall/flush.
// Optional signed-overflow trap on ADD/SUB is enabled by defining ALU_OVF_EN.
module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [3:0]    alu_control,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  input  logic [RW-1:0] rd_addr,
  input  logic          reg_write_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic [DW-1:0] store_data_in,
  input  logic          stall,
  input  logic          flush,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_result,
  output logic          mem_zero,
  output logic [RW-1:0] mem_rd_addr,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic [DW-1:0] mem_store_data,
  output logic          mem_ovf,
  output logic          err_illegal
);
  localparam int SW = $clog2(DW);
  logic [DW-1:0] res;
  logic illegal, ovf, ok;
  // X/Z codes match no case item and fall into the illegal default
  always_comb begin
    res = '0;
    illegal = 1'b0;
    case (alu_control)
      4'b0000: res = alu_a + alu_b;
      4'b0001: res = alu_a - alu_b;
      4'b0010: res = alu_a & alu_b;
      4'b0011: res = alu_a | alu_b;
      4'b0100: res = ~(alu_a | alu_b);
      4'b0101: res = alu_a ^ alu_b;
      4'b0110: res = alu_a << alu_b[SW-1:0];
      4'b0111: res = alu_a >> alu_b[SW-1:0];
      4'b1000: res = alu_a;
      default: illegal = 1'b1;
    endcase
  end
`ifdef ALU_OVF_EN
  assign ovf = (alu_control == 4'b0000 && alu_a[DW-1] == alu_b[DW-1] && res[DW-1] != alu_a[DW-1]) ||
               (alu_control == 4'b0001 && alu_a[DW-1] != alu_b[DW-1] && res[DW-1] != alu_a[DW-1]);
`else
  assign ovf = 1'b0;
`endif
  assign ok = ex_valid & ~illegal;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_zero       <= 1'b0;
      mem_rd_addr    <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
      mem_ovf        <= 1'b0;
      if (rst) err_illegal <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_alu_result <= ex_valid ? res : '0;
      mem_zero       <= ex_valid && res == '0;
      mem_rd_addr    <= ex_valid ? rd_addr : '0;
      mem_reg_write  <= ok & reg_write_in & ~ovf;
      mem_mem_read   <= ok & mem_read_in;
      mem_mem_write  <= ok & mem_write_in;
      mem_store_data <= ex_valid ? store_data_in : '0;
      mem_ovf        <= ex_valid & ovf;
      err_illegal    <= err_illegal | (ex_valid & illegal);
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage against an arithmetic reference model.
module tb_ex_mem_stage;
  localparam int DW = 16, RW = 3;
  logic clk = 0, rst = 1, ex_valid = 0, reg_write_in = 0, mem_read_in = 0, mem_write_in = 0;
  logic stall = 0, flush = 0;
  logic [3:0] alu_control = 0;
  logic [DW-1:0] alu_a = 0, alu_b = 0, store_data_in = 0;
  logic [RW-1:0] rd_addr = 0;
  logic mem_valid, mem_zero, mem_reg_write, mem_mem_read, mem_mem_write, mem_ovf, err_illegal;
  logic [DW-1:0] mem_alu_result, mem_store_data;
  logic [RW-1:0] mem_rd_addr;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .rd_addr(rd_addr), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .store_data_in(store_data_in),
    .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_zero(mem_zero), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data),
    .mem_ovf(mem_ovf), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {int v, res, z, rd, rw, mr, mw, sd, ovf, err;} exp_t;
  exp_t m = '{default: 0};
  exp_t q[$];
  int errors = 0, checks = 0;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int sgn(int x);
    return x >= 32768 ? x - 65536 : x;
  endfunction

  task automatic step(bit r, bit f, bit s, bit v, int op, int a, int b, int rd, bit rw, bit mr, bit mw, int sd);
    int res, o, sh, e;
    bit ill;
    @(negedge clk);
    rst = r; flush = f; stall = s; ex_valid = v; alu_control = op[3:0];
    alu_a = a[DW-1:0]; alu_b = b[DW-1:0]; rd_addr = rd[RW-1:0];
    reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; store_data_in = sd[DW-1:0];
    e = m.err;
    if (r) m = '{default: 0};
    else if (f || (!s && !v)) begin
      m = '{default: 0};
      m.err = e;
    end else if (!s) begin
      ill = 0; o = 0; res = 0; sh = b % 16;
      case (op)
        0: begin res = (a + b) % 65536; o = (sgn(a) + sgn(b) > 32767) || (sgn(a) + sgn(b) < -32768); end
        1: begin res = (a - b + 65536) % 65536; o = (sgn(a) - sgn(b) > 32767) || (sgn(a) - sgn(b) < -32768); end
        2: res = a & b;
        3: res = a | b;
        4: res = 65535 - (a | b);
        5: res = a ^ b;
        6: res = (a * (1 << sh)) % 65536;
        7: res = a / (1 << sh);
        8: res = a;
        default: ill = 1;
      endcase
`ifndef ALU_OVF_EN
      o = 0;
`endif
      m = '{v: 1, res: res, z: int'(res == 0), rd: rd, rw: int'(!ill && rw && o == 0),
            mr: int'(!ill && mr), mw: int'(!ill && mw), sd: sd, ovf: o, err: e | int'(ill)};
    end
    q.push_back(m);
  endtask

  initial forever begin
    exp_t x;
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("valid", int'(mem_valid), x.v);
      chk("result", int'(mem_alu_result), x.res);
      chk("zero", int'(mem_zero), x.z);
      chk("rd_addr", int'(mem_rd_addr), x.rd);
      chk("reg_write", int'(mem_reg_write), x.rw);
      chk("mem_read", int'(mem_mem_read), x.mr);
      chk("mem_write", int'(mem_mem_write), x.mw);
      chk("store_data", int'(mem_store_data), x.sd);
      chk("ovf", int'(mem_ovf), x.ovf);
      chk("err_illegal", int'(err_illegal), x.err);
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 5, 5, 1, 1, 1, 1, 9);
    step(0, 0, 0, 1, 0, 'h7FFF, 1, 3, 1, 0, 0, 'h55);
    step(0, 0, 0, 1, 1, 'h1234, 'h1234, 2, 1, 0, 0, 0);
    step(0, 0, 0, 1, 4, 'h0F0F, 'h00FF, 4, 1, 0, 0, 0);
    step(0, 0, 0, 1, 6, 1, 'h13, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 7, 'h8000, 'h0F, 6, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 2, 3, 7, 1, 0, 0, 'hAA);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 100 + i, 7, i, 1, 1, 0, i);
    step(0, 0, 0, 1, 3, 'hF000, 'h000F, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 1, 1, 2, 1, 1, 1, 3);
    step(0, 0, 0, 1, 'b1010, 4, 4, 3, 1, 0, 1, 'h77);
    step(0, 0, 0, 1, 0, 1, 1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 5, 'hFFFF, 'h00FF, 3, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 8, 'h8001, 0, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 'h8000, 1, 3, 1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int op;
      op = ($urandom % 4 == 0) ? 9 + int'($urandom % 7) : int'($urandom % 9);
      step($urandom % 60 == 0, $urandom % 10 == 0, $urandom % 5 == 0, $urandom % 6 != 0, op,
           int'($urandom % 65536), int'($urandom % 65536), int'($urandom % 8),
           $urandom % 2 == 1, $urandom % 2 == 1, $urandom % 2 == 1, int'($urandom % 65536));
    end
    @(posedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
